// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker: buffers reference bits in a FIFO and compares them with decoded bits.
// Optional longest-mismatch-burst tracking is enabled by defining BER_BURST_EN.
module viterbi_ber_checker #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned WINDOW = 256,
   parameter int unsigned CW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          ref_valid_i,
   input  logic          ref_i,
   input  logic          dec_valid_i,
   input  logic          dec_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [CW-1:0] bit_ct_o,
   output logic [CW-1:0] err_ct_o,
   output logic          mismatch_o,
   output logic          ovf_o,
   output logic          unf_o
`ifdef BER_BURST_EN
   ,
   output logic [CW-1:0] max_burst_o
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          r_state;
   logic [DEPTH-1:0] r_mem;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_occ;
   logic [CW-1:0]   r_bit_ct;
   logic [CW-1:0]   r_err_ct;
   logic            r_busy;
   logic            r_done;
   logic            r_mismatch;
   logic            r_ovf;
   logic            r_unf;

   logic w_run;
   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;
   logic w_unf;
   logic w_head;
   logic w_mis;

   // The start_i cycle performs no push or pop.
   assign w_run   = (r_state == StRun) && !start_i;
   assign w_full  = (r_occ == (AW+1)'(DEPTH));
   assign w_empty = (r_occ == '0);
   assign w_pop   = w_run && dec_valid_i && !w_empty;
   assign w_unf   = w_run && dec_valid_i && w_empty;
   assign w_push  = w_run && ref_valid_i && (!w_full || w_pop);
   assign w_drop  = w_run && ref_valid_i && w_full && !w_pop;
   assign w_head  = r_mem[r_rd_ptr];
   assign w_mis   = w_pop && (w_head != dec_i);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= ref_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_bit_ct   <= '0;
         r_err_ct   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_mismatch <= 1'b0;
         if (start_i) begin
            r_state  <= StRun;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_bit_ct <= '0;
            r_err_ct <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
         end else begin
            case (r_state)
               StRun: begin
                  if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_pop) begin
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                     r_bit_ct <= r_bit_ct + 1'b1;
                     if (w_mis) begin
                        r_err_ct   <= r_err_ct + 1'b1;
                        r_mismatch <= 1'b1;
                     end
                     if (r_bit_ct == CW'(WINDOW - 1)) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
                  if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
                  else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
                  if (w_drop) r_ovf <= 1'b1;
                  if (w_unf)  r_unf <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign bit_ct_o   = r_bit_ct;
   assign err_ct_o   = r_err_ct;
   assign mismatch_o = r_mismatch;
   assign ovf_o      = r_ovf;
   assign unf_o      = r_unf;

`ifdef BER_BURST_EN
   logic [CW-1:0] r_run_ct;
   logic [CW-1:0] r_max_burst;
   logic [CW-1:0] w_run_nx;

   assign w_run_nx = (r_run_ct == '1) ? r_run_ct : r_run_ct + 1'b1;

   always_ff @(posedge clk) begin
      if (rst || start_i) begin
         r_run_ct    <= '0;
         r_max_burst <= '0;
      end else if (w_pop) begin
         if (w_mis) begin
            r_run_ct <= w_run_nx;
            if (w_run_nx > r_max_burst) r_max_burst <= w_run_nx;
         end else begin
            r_run_ct <= '0;
         end
      end
   end

   assign max_burst_o = r_max_burst;
`endif

endmodule
